uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, sets sysclk cycles per serial bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the transmit FIFO depth in bytes; legal values are powers of two, 2..16.
REQ-003 sysclk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 TX_DATA  input  8  byte to transmit; sampled when ctrl is high.
REQ-006 ctrl  input  1  single-cycle write strobe from the peripheral register block.
REQ-007 TX_STATUS  output  1  high when the FIFO can accept a byte (not full).
REQ-008 tx_busy  output  1  high while a frame is on the line (state not IDLE) or the FIFO is non-empty.
REQ-009 tx_ovf  output  1  sticky overflow flag; set when a write is dropped.
REQ-010 PC_Uart_txd  output  1  registered serial line, 8N1 format, idle high.

Function
REQ-011 The frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-012 When ctrl=1 and the FIFO is not full at the edge, the edge SHALL write TX_DATA into the FIFO.
  - ctrl=1 with the FIFO full: the byte is dropped, tx_ovf is set to 1, and FIFO contents are unchanged.
  - A pop in the same cycle does not make room for that write.
REQ-013 The FIFO SHALL have FIFO_DEPTH entries with wrapping read/write pointers and an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous write and pop (not full) leaves the count unchanged.
REQ-014 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE -> START: at the first edge where the FIFO is non-empty, the FSM pops the head into an 8-bit shift register, clears the baud counter, and drives txd=0.
REQ-016 START -> DATA: after CLKS_PER_BIT cycles, txd = shift[0] and the bit index is cleared.
REQ-017 DATA: every CLKS_PER_BIT cycles the register shifts right and the bit index increments; after bit 7 has been held CLKS_PER_BIT cycles, go to STOP with txd=1.
REQ-018 STOP exit: after CLKS_PER_BIT cycles, go to START (popping the next byte on that edge) if the FIFO is non-empty, otherwise go to IDLE.
  - Back-to-back frames therefore have no idle gap.
REQ-019 Latency: a write at edge N into an empty FIFO in IDLE SHALL pop at edge N+1, with txd low from edge N+1.
  - The full frame occupies exactly 10*CLKS_PER_BIT cycles.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.
  - It is reset on every START entry, so bit timing is independent of write timing.
REQ-021 TX_STATUS SHALL be combinational from the count: (count != FIFO_DEPTH).
REQ-022 tx_busy SHALL be combinational: (state != IDLE) or (count != 0).
REQ-023 PC_Uart_txd SHALL be driven from a flop; no combinational path from any input to txd.
REQ-024 ctrl held high for k cycles SHALL enqueue k bytes, subject to the full rule.

Reset
REQ-025 reset low SHALL immediately force the following, regardless of clock:
  - state IDLE, PC_Uart_txd=1, FIFO pointers and count 0, baud counter and bit index 0;
  - tx_ovf=0, TX_STATUS=1, tx_busy=0.
REQ-026 reset asserted mid-frame SHALL abort the frame: txd returns high at once, and queued bytes are discarded.
REQ-027 After reset deasserts, the first write SHALL behave per REQ-019 with no residual state.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte: write 0x55 at edge N.
  - Expect txd = 0,1,0,1,0,1,0,1,0,1 in 4-cycle bits from edge N+1, then txd=1.
  - Expect tx_busy to fall at edge N+41.
REQ-029 Back-to-back: write 0xA5 then 0x3C on consecutive cycles.
  - Expect two contiguous 40-cycle frames with no idle cycle between them.
  - Expect decoded bytes 0xA5 then 0x3C.
REQ-030 Overflow: while idle, write 6 bytes on 6 consecutive cycles.
  - Entry 1 is popped at edge 2, so writes 1..5 are accepted and write 6 is dropped.
  - Expect TX_STATUS=0 after write 5, tx_ovf=1 after write 6, and exactly five frames out.
REQ-031 Full plus pop collision: with the FIFO full, assert ctrl on the STOP->START pop edge.
  - Expect the byte dropped, tx_ovf=1, and count = 3 after that edge.
REQ-032 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - Expect txd=1 asynchronously and TX_STATUS=1, tx_busy=0, tx_ovf=0.
  - Expect no further frames until a new write.
REQ-033 Long idle: no writes for 1000 cycles.
  - Expect txd constantly 1 and tx_busy=0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Register-side bus of the UART transmitter: write strobe and data in,
// status, overflow, serial line and FSM debug state out.
interface uart_tx_if;
  logic [7:0] TX_DATA;
  logic       ctrl;
  logic       TX_STATUS;
  logic       tx_busy;
  logic       tx_ovf;
  logic       PC_Uart_txd;
  logic [1:0] dbg_state;

  // Handshake: ctrl is the valid strobe and TX_STATUS the ready; a byte moves
  // on an edge where both are high. ctrl with TX_STATUS low drops the byte and
  // sets tx_ovf. ctrl need not wait for ready and is never back-pressured.
  modport master (
    output TX_DATA, ctrl,
    input  TX_STATUS, tx_busy, tx_ovf, PC_Uart_txd, dbg_state
  );

  modport slave (
    input  TX_DATA, ctrl,
    output TX_STATUS, tx_busy, tx_ovf, PC_Uart_txd, dbg_state
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// Frames go out back to back while the FIFO holds data; the line idles high.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic     sysclk,
  input  logic     reset,
  uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            ovf_q, ovf_d;

  logic full, empty, push, pop, bit_done;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // Fullness is judged before any pop on the same edge, so a pop never makes room.
  assign push     = bus.ctrl & ~full;
  assign bit_done = (baud_q == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_d    = '0;
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    ovf_d    = ovf_q | (bus.ctrl & full);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.TX_DATA;
    end
  end

  assign bus.TX_STATUS   = ~full;
  assign bus.tx_busy     = (state_q != S_IDLE) | ~empty;
  assign bus.tx_ovf      = ovf_q;
  assign bus.PC_Uart_txd = txd_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 4 clocks per bit, 4-deep FIFO: directed steps plus
// random bursts, with a line decoder checked against a queue of accepted bytes.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int         pass_cnt   = 0;
  int         total_cnt  = 0;
  int         frames_exp = 0;
  int         frames_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] burst[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b);
    exp_q.push_back(b);
    frames_exp++;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (bus.tx_busy === 1'b1 && guard < 2000) begin
      step();
      guard++;
    end
    chk(tag, 32'(bus.tx_busy), 32'(0));
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b0;
    #1;
    chk("rst_txd",    32'(bus.PC_Uart_txd), 32'(1));
    chk("rst_status", 32'(bus.TX_STATUS),   32'(1));
    chk("rst_busy",   32'(bus.tx_busy),     32'(0));
    chk("rst_ovf",    32'(bus.tx_ovf),      32'(0));
    exp_q.delete();
    frames_exp = frames_seen;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Writes k bytes on consecutive edges from idle; all k<=5 fit, and the
  // frames must run back to back, so busy lasts exactly 40*k+1 samples.
  task automatic run_burst(input int k, input string tag);
    int busy_n;
    int guard;
    busy_n = 0;
    for (int i = 0; i < k; i++) begin
      bus.TX_DATA = burst[i];
      bus.ctrl    = 1'b1;
      accept(burst[i]);
      step();
      if (bus.tx_busy === 1'b1) busy_n++;
    end
    bus.ctrl = 1'b0;
    guard = 0;
    while (bus.tx_busy === 1'b1 && guard < 1000) begin
      step();
      guard++;
      if (bus.tx_busy === 1'b1) busy_n++;
    end
    chk(tag, 32'(busy_n), 32'(10 * CPB * k + 1));
  endtask

  // Line decoder: finds a falling edge, samples each bit mid-way.
  initial begin : line_monitor
    logic       prev;
    bit         active;
    int         t;
    int         bi;
    logic [7:0] b;
    prev = 1'b1; active = 1'b0; t = 0; b = '0;
    forever begin
      step();
      if (reset !== 1'b1) begin
        active = 1'b0;
        prev   = 1'b1;
      end else begin
        if (active) begin
          t++;
          if (t >= 2 && ((t - 2) % CPB) == 0) begin
            bi = (t - 2) / CPB;
            if (bi == 0) chk("mon_start_bit", 32'(bus.PC_Uart_txd), 32'(0));
            else if (bi <= 8) b[bi-1] = bus.PC_Uart_txd;
            else begin
              chk("mon_stop_bit", 32'(bus.PC_Uart_txd), 32'(1));
              frames_seen++;
              chk("mon_frame_expected", 32'(exp_q.size() > 0), 32'(1));
              if (exp_q.size() > 0) chk("mon_frame_byte", 32'(b), 32'(exp_q.pop_front()));
              active = 1'b0;
            end
          end
        end else if (prev === 1'b1 && bus.PC_Uart_txd === 1'b0) begin
          active = 1'b1;
          t      = 0;
        end
        prev = bus.PC_Uart_txd;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    int         j;
    logic       exp_bit;
    int         bad;
    int         seen0;
    int         k;

    bus.TX_DATA = '0;
    bus.ctrl    = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("por_txd",    32'(bus.PC_Uart_txd), 32'(1));
    chk("por_status", 32'(bus.TX_STATUS),   32'(1));
    chk("por_busy",   32'(bus.tx_busy),     32'(0));
    chk("por_ovf",    32'(bus.tx_ovf),      32'(0));
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single byte 0x55, cycle-exact waveform.
    d = 8'h55;
    bus.TX_DATA = d;
    bus.ctrl    = 1'b1;
    accept(d);
    step();
    bus.ctrl = 1'b0;
    chk("single_txd_n",  32'(bus.PC_Uart_txd), 32'(1));
    chk("single_busy_n", 32'(bus.tx_busy),     32'(1));
    for (int c = 1; c <= 10 * CPB; c++) begin
      step();
      j = (c - 1) / CPB;
      if (j == 0)      exp_bit = 1'b0;
      else if (j <= 8) exp_bit = d[j-1];
      else             exp_bit = 1'b1;
      chk("single_txd",  32'(bus.PC_Uart_txd), 32'(exp_bit));
      chk("single_busy", 32'(bus.tx_busy),     32'(1));
    end
    step();
    chk("single_busy_n41", 32'(bus.tx_busy),     32'(0));
    chk("single_txd_n41",  32'(bus.PC_Uart_txd), 32'(1));

    // Back-to-back pair.
    step();
    burst[0] = 8'hA5;
    burst[1] = 8'h3C;
    run_burst(2, "b2b_busy_len");

    // Random bursts with random gaps.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 20)) step();
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) burst[i] = 8'($urandom);
      run_burst(k, "rand_busy_len");
    end
    chk("rand_frames", 32'(frames_seen), 32'(frames_exp));

    // Overflow: six writes from idle, the sixth is dropped.
    step();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bus.TX_DATA = d;
      bus.ctrl    = 1'b1;
      if (i < 5) accept(d);
      step();
      if (i == 4) begin
        chk("ovf_status_w5", 32'(bus.TX_STATUS), 32'(0));
        chk("ovf_flag_w5",   32'(bus.tx_ovf),    32'(0));
      end
      if (i == 5) begin
        chk("ovf_flag_w6",   32'(bus.tx_ovf),    32'(1));
        chk("ovf_status_w6", 32'(bus.TX_STATUS), 32'(0));
      end
    end
    bus.ctrl = 1'b0;
    wait_idle("ovf_idle");
    chk("ovf_frames", 32'(frames_seen), 32'(frames_exp));

    // Full FIFO plus write on the STOP->START pop edge.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      bus.TX_DATA = d;
      bus.ctrl    = 1'b1;
      accept(d);
      step();
    end
    bus.ctrl = 1'b0;
    chk("col_full_after_fill", 32'(bus.TX_STATUS), 32'(0));
    repeat (10 * CPB - 4) step();
    chk("col_full_pre_edge", 32'(bus.TX_STATUS), 32'(0));
    chk("col_ovf_pre_edge",  32'(bus.tx_ovf),    32'(0));
    bus.TX_DATA = 8'hEE;
    bus.ctrl    = 1'b1;
    step();
    bus.ctrl = 1'b0;
    chk("col_status_post", 32'(bus.TX_STATUS), 32'(1));
    chk("col_ovf_post",    32'(bus.tx_ovf),    32'(1));
    wait_idle("col_idle");
    chk("col_frames", 32'(frames_seen), 32'(frames_exp));

    // Reset during DATA bit 3 with two bytes queued.
    for (int i = 0; i < 3; i++) begin
      bus.TX_DATA = 8'($urandom);
      bus.ctrl    = 1'b1;
      accept(bus.TX_DATA);
      step();
    end
    bus.ctrl = 1'b0;
    repeat (16) step();
    chk("mid_busy_before", 32'(bus.tx_busy), 32'(1));
    seen0 = frames_seen;
    pulse_reset();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.PC_Uart_txd !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("mid_quiet_cycles", 32'(bad), 32'(0));
    chk("mid_no_frames", 32'(frames_seen), 32'(seen0));

    // First write after reset keeps the one-edge latency.
    d = 8'hC3;
    bus.TX_DATA = d;
    bus.ctrl    = 1'b1;
    accept(d);
    step();
    bus.ctrl = 1'b0;
    chk("post_rst_txd_n",  32'(bus.PC_Uart_txd), 32'(1));
    step();
    chk("post_rst_txd_n1", 32'(bus.PC_Uart_txd), 32'(0));
    wait_idle("post_rst_idle");

    // Long idle.
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (bus.PC_Uart_txd !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("long_idle", 32'(bad), 32'(0));

    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("final_frames",      32'(frames_seen),  32'(frames_exp));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
